// File: rtl/apb2axi_pkg.sv
// rtl/apb2axi_pkg.sv - shared types and constants for the APB-to-AXI completion path
package apb2axi_pkg;

    localparam int CPL_TAG_W    = 4;
    localparam int CPL_BEAT_W   = 9;
    localparam int CQ_DEPTH_DEF = 4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [CPL_TAG_W-1:0]  tag;
        logic [1:0]            resp;
        logic [CPL_BEAT_W-1:0] num_beats;
        logic                  error;
    } completion_entry_t;

    // SLVERR and DECERR are the only responses that flag a failed transaction
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp >= AXI_RESP_SLVERR;
    endfunction

endpackage

// File: rtl/apb2axi_cq_fifo.sv
// rtl/apb2axi_cq_fifo.sv - synchronous FIFO of completion entries
module apb2axi_cq_fifo
    import apb2axi_pkg::*;
#(
    parameter int DEPTH = CQ_DEPTH_DEF,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  completion_entry_t push_entry,
    input  logic              pop,
    output completion_entry_t head,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    completion_entry_t mem_q [DEPTH];
    completion_entry_t mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state: a full FIFO may still take a push when it pops the same cycle
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // State registers; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/apb2axi_completion_queue.sv
// rtl/apb2axi_completion_queue.sv - per-tag AXI R/B collection into an ordered completion queue
module apb2axi_completion_queue
    import apb2axi_pkg::*;
#(
    parameter int TAG_W    = CPL_TAG_W,
    parameter int DATA_W   = 64,
    parameter int BEAT_W   = CPL_BEAT_W,
    parameter int CQ_DEPTH = CQ_DEPTH_DEF
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              axi_rvalid,
    input  logic [TAG_W-1:0]  axi_rid,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast,
    output logic              axi_rready,
    input  logic              axi_bvalid,
    input  logic [TAG_W-1:0]  axi_bid,
    input  logic [1:0]        axi_bresp,
    output logic              axi_bready,
    output logic              rdb_wr_en,
    output logic [TAG_W-1:0]  rdb_wr_tag,
    output logic [BEAT_W-1:0] rdb_wr_beat,
    output logic [DATA_W-1:0] rdb_wr_data,
    output logic              cq_dir_cpl_vld,
    output completion_entry_t cq_dir_cpl_entry,
    input  logic              cq_dir_cpl_rdy
);

    localparam int NTAG = 2 ** TAG_W;
    localparam int CW   = $clog2(CQ_DEPTH) + 1;

    logic              ready_en_q, ready_en_d;
    logic [BEAT_W-1:0] beat_cnt_q [NTAG];
    logic [BEAT_W-1:0] beat_cnt_d [NTAG];
    logic [1:0]        worst_resp_q [NTAG];
    logic [1:0]        worst_resp_d [NTAG];

    logic              space_ok;
    logic              r_hs;
    logic              b_hs;
    logic [BEAT_W-1:0] cur_beat;
    logic [BEAT_W-1:0] next_beat;
    logic [1:0]        final_resp;
    logic              push_req;
    completion_entry_t push_entry;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    completion_entry_t fifo_head;

    // Handshakes, data-buffer strobe, per-tag accumulation and push selection.
    // A same-cycle R-last beats a B response so only one entry is pushed per cycle.
    always_comb begin
        ready_en_d   = 1'b1;
        space_ok     = (fifo_count < CW'(CQ_DEPTH));
        axi_rready   = ready_en_q && space_ok;
        axi_bready   = ready_en_q && space_ok && !(axi_rvalid && axi_rlast);
        r_hs         = axi_rvalid && axi_rready;
        b_hs         = axi_bvalid && axi_bready;

        cur_beat     = beat_cnt_q[axi_rid];
        next_beat    = (cur_beat == '1) ? cur_beat : cur_beat + BEAT_W'(1);
        final_resp   = (axi_rresp > worst_resp_q[axi_rid]) ? axi_rresp : worst_resp_q[axi_rid];

        rdb_wr_en    = r_hs;
        rdb_wr_tag   = r_hs ? axi_rid   : '0;
        rdb_wr_beat  = r_hs ? cur_beat  : '0;
        rdb_wr_data  = r_hs ? axi_rdata : '0;

        beat_cnt_d   = beat_cnt_q;
        worst_resp_d = worst_resp_q;
        push_req     = 1'b0;
        push_entry   = '0;

        if (r_hs) begin
            if (axi_rlast) begin
                beat_cnt_d[axi_rid]   = '0;
                worst_resp_d[axi_rid] = AXI_RESP_OKAY;
                push_req              = 1'b1;
                push_entry.tag        = axi_rid;
                push_entry.resp       = final_resp;
                push_entry.num_beats  = next_beat;
                push_entry.error      = resp_is_error(final_resp);
            end else begin
                beat_cnt_d[axi_rid]   = next_beat;
                worst_resp_d[axi_rid] = final_resp;
            end
        end else if (b_hs) begin
            push_req             = 1'b1;
            push_entry.tag       = axi_bid;
            push_entry.resp      = axi_bresp;
            push_entry.num_beats = '0;
            push_entry.error     = resp_is_error(axi_bresp);
        end

        cq_dir_cpl_vld   = !fifo_empty;
        cq_dir_cpl_entry = fifo_empty ? '0 : fifo_head;
    end

    // Per-tag state and the ready enable that opens the AXI channels after reset
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ready_en_q <= 1'b0;
            for (int i = 0; i < NTAG; i++) begin
                beat_cnt_q[i]   <= '0;
                worst_resp_q[i] <= '0;
            end
        end else begin
            ready_en_q   <= ready_en_d;
            beat_cnt_q   <= beat_cnt_d;
            worst_resp_q <= worst_resp_d;
        end
    end

    apb2axi_cq_fifo #(
        .DEPTH (CQ_DEPTH)
    ) u_cq_fifo (
        .clk        (pclk),
        .rst_n      (presetn),
        .push       (push_req && !fifo_full),
        .push_entry (push_entry),
        .pop        (cq_dir_cpl_rdy),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_apb2axi_completion_queue.sv
// tb/tb_apb2axi_completion_queue.sv - randomized and directed bench with a behavioural completion model
module tb_apb2axi_completion_queue;
    import apb2axi_pkg::*;

    logic              pclk = 1'b0;
    logic              presetn = 1'b0;
    logic              axi_rvalid = 1'b0;
    logic [3:0]        axi_rid = '0;
    logic [63:0]       axi_rdata = '0;
    logic [1:0]        axi_rresp = '0;
    logic              axi_rlast = 1'b0;
    logic              axi_rready;
    logic              axi_bvalid = 1'b0;
    logic [3:0]        axi_bid = '0;
    logic [1:0]        axi_bresp = '0;
    logic              axi_bready;
    logic              rdb_wr_en;
    logic [3:0]        rdb_wr_tag;
    logic [8:0]        rdb_wr_beat;
    logic [63:0]       rdb_wr_data;
    logic              cq_dir_cpl_vld;
    completion_entry_t cq_dir_cpl_entry;
    logic              cq_dir_cpl_rdy = 1'b0;

    always #5 pclk = ~pclk;

    apb2axi_completion_queue dut (
        .pclk             (pclk),
        .presetn          (presetn),
        .axi_rvalid       (axi_rvalid),
        .axi_rid          (axi_rid),
        .axi_rdata        (axi_rdata),
        .axi_rresp        (axi_rresp),
        .axi_rlast        (axi_rlast),
        .axi_rready       (axi_rready),
        .axi_bvalid       (axi_bvalid),
        .axi_bid          (axi_bid),
        .axi_bresp        (axi_bresp),
        .axi_bready       (axi_bready),
        .rdb_wr_en        (rdb_wr_en),
        .rdb_wr_tag       (rdb_wr_tag),
        .rdb_wr_beat      (rdb_wr_beat),
        .rdb_wr_data      (rdb_wr_data),
        .cq_dir_cpl_vld   (cq_dir_cpl_vld),
        .cq_dir_cpl_entry (cq_dir_cpl_entry),
        .cq_dir_cpl_rdy   (cq_dir_cpl_rdy)
    );

    typedef struct {
        int tag;
        int resp;
        int nb;
        int err;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   m_cnt   [16];
    int   m_worst [16];
    bit   m_ready_en;
    exp_t m_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit rv, input int rid, input int rresp, input bit rlast,
                          input bit bv, input int bid, input int bresp, input bit rdy);
        axi_rvalid     = rv;
        axi_rid        = 4'(rid);
        axi_rresp      = 2'(rresp);
        axi_rlast      = rlast;
        axi_rdata      = {$urandom, $urandom};
        axi_bvalid     = bv;
        axi_bid        = 4'(bid);
        axi_bresp      = 2'(bresp);
        cq_dir_cpl_rdy = rdy;
    endtask

    // One clock: check outputs at the falling edge, then advance the model across the rising edge
    task automatic step();
        bit   exp_rr, exp_br, r_hs, b_hs;
        int   t, fr;
        exp_t e;
        @(negedge pclk);
        exp_rr = m_ready_en && (m_q.size() < 4);
        exp_br = exp_rr && !(axi_rvalid && axi_rlast);
        r_hs   = axi_rvalid && exp_rr;
        b_hs   = axi_bvalid && exp_br;
        check("rready", 64'(axi_rready), 64'(exp_rr));
        check("bready", 64'(axi_bready), 64'(exp_br));
        check("rdb_en", 64'(rdb_wr_en), 64'(r_hs));
        if (r_hs) begin
            t = int'(axi_rid);
            check("rdb_tag", 64'(rdb_wr_tag), 64'(t));
            check("rdb_beat", 64'(rdb_wr_beat), 64'(m_cnt[t]));
            check("rdb_data", rdb_wr_data, axi_rdata);
        end
        check("cpl_vld", 64'(cq_dir_cpl_vld), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("cpl_tag", 64'(cq_dir_cpl_entry.tag), 64'(m_q[0].tag));
            check("cpl_resp", 64'(cq_dir_cpl_entry.resp), 64'(m_q[0].resp));
            check("cpl_beats", 64'(cq_dir_cpl_entry.num_beats), 64'(m_q[0].nb));
            check("cpl_err", 64'(cq_dir_cpl_entry.error), 64'(m_q[0].err));
        end
        if (m_q.size() > 0 && cq_dir_cpl_rdy) begin
            void'(m_q.pop_front());
        end
        if (r_hs) begin
            t  = int'(axi_rid);
            fr = (int'(axi_rresp) > m_worst[t]) ? int'(axi_rresp) : m_worst[t];
            if (axi_rlast) begin
                e.tag  = t;
                e.resp = fr;
                e.nb   = m_cnt[t] + 1;
                e.err  = (fr >= 2) ? 1 : 0;
                m_q.push_back(e);
                m_cnt[t]   = 0;
                m_worst[t] = 0;
            end else begin
                m_cnt[t]   = m_cnt[t] + 1;
                m_worst[t] = fr;
            end
        end else if (b_hs) begin
            e.tag  = int'(axi_bid);
            e.resp = int'(axi_bresp);
            e.nb   = 0;
            e.err  = (int'(axi_bresp) >= 2) ? 1 : 0;
            m_q.push_back(e);
        end
        @(posedge pclk);
        m_ready_en = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        presetn = 1'b0;
        #1;
        m_ready_en = 1'b0;
        m_q.delete();
        for (int i = 0; i < 16; i++) begin
            m_cnt[i]   = 0;
            m_worst[i] = 0;
        end
        check("rst_vld", 64'(cq_dir_cpl_vld), 64'(0));
        check("rst_rready", 64'(axi_rready), 64'(0));
        check("rst_bready", 64'(axi_bready), 64'(0));
        check("rst_rdb_en", 64'(rdb_wr_en), 64'(0));
        check("rst_entry", 64'(cq_dir_cpl_entry), 64'(0));
        @(posedge pclk);
        @(posedge pclk);
        #1;
        presetn = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();
        step();

        // Tag 3, four OKAY beats
        for (int i = 0; i < 4; i++) begin
            set_in(1, 3, 0, i == 3, 0, 0, 0, 1);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        step();

        // Tag 5 with a SLVERR in the middle
        set_in(1, 5, 0, 0, 0, 0, 0, 1); step();
        set_in(1, 5, 2, 0, 0, 0, 0, 1); step();
        set_in(1, 5, 0, 1, 0, 0, 0, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 1); step();

        // Interleaved tags 1 and 2
        set_in(1, 1, 0, 0, 0, 0, 0, 1); step();
        set_in(1, 2, 1, 0, 0, 0, 0, 1); step();
        set_in(1, 1, 0, 1, 0, 0, 0, 1); step();
        set_in(1, 2, 0, 1, 0, 0, 0, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 1); step();
        step();

        // R-last tag 4 collides with B tag 6
        set_in(1, 4, 0, 1, 1, 6, 3, 1); step();
        set_in(0, 0, 0, 0, 1, 6, 3, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 1); step();
        step();

        // Fill the queue with the directory stalled, then drain
        for (int i = 0; i < 4; i++) begin
            set_in(1, 8 + i, i, 1, 0, 0, 0, 0);
            step();
        end
        set_in(1, 12, 0, 1, 1, 13, 0, 0); step();
        step();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1);
            step();
        end

        // Reset with a partial burst of tag 7 and two queued entries
        set_in(0, 0, 0, 0, 1, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 1, 1, 2, 0); step();
        set_in(1, 7, 3, 0, 0, 0, 0, 0); step();
        set_in(1, 7, 0, 0, 0, 0, 0, 0); step();
        do_reset();
        step();
        set_in(1, 7, 0, 1, 0, 0, 0, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 1); step();
        step();

        // Random traffic, with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 3),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15),
                   $urandom_range(0, 3), $urandom_range(0, 3) != 0);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
